// File: rtl/gol_frame_scanner.sv
// Captures Game of Life generations from the engine's serial OUTPUT stream and
// scans the committed frame onto an N-row LED matrix. Define GOL_SCAN_BLANK_EN to blank row_sel on dwell count 0.
module gol_frame_scanner #(
    parameter int N     = 8,
    parameter int DWELL = 16,
    parameter int GEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       phase,
    input  logic             cell_in,
    output logic [N-1:0]     row_sel,
    output logic [N-1:0]     col_out,
    output logic [GEN_W-1:0] generation,
    output logic             frame_valid,
    output logic             extinct,
    output logic             still_life
);

    localparam int FB = N * N;
    localparam int KW = (FB > 1) ? $clog2(FB) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST     = KW'(FB - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
    localparam logic [1:0]    PH_INPUT   = 2'b00;
    localparam logic [1:0]    PH_OUTPUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_COMMIT  = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_armed;
    logic [KW-1:0]         r_k;
    logic [FB-1:0]         r_shadow;
    logic [N-1:0][N-1:0]   r_display;
    logic [DW-1:0]         r_dwell;
    logic [RW-1:0]         r_row;

    logic                  w_out;
    logic                  w_in;
    logic                  w_start;
    logic                  w_store;
    logic                  w_commit;
    logic [DW-1:0]         w_dwell_nxt;
    logic [RW-1:0]         w_row_nxt;
    logic [N-1:0]          w_sel_nxt;

    assign w_out = (phase == PH_OUTPUT);
    assign w_in  = (phase == PH_INPUT);

    // Capture FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM next-state logic; leaving OUTPUT mid-frame aborts to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_out && r_armed) w_state_nxt = S_CAPTURE;
                else                  w_state_nxt = S_IDLE;
            end
            S_CAPTURE: begin
                if (!w_out)            w_state_nxt = S_IDLE;
                else if (r_k == K_LAST) w_state_nxt = S_COMMIT;
                else                   w_state_nxt = S_CAPTURE;
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Capture FSM output decode
    always_comb begin
        w_start  = 1'b0;
        w_store  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE:    w_start  = w_out && r_armed;
            S_CAPTURE: w_store  = w_out;
            S_COMMIT:  w_commit = 1'b1;
            default:   w_commit = 1'b0;
        endcase
    end

    // Shadow deserializer and one-frame-per-OUTPUT-phase arming
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= {FB{1'b0}};
            r_k      <= {KW{1'b0}};
            r_armed  <= 1'b1;
        end else begin
            if (!w_out)       r_armed <= 1'b1;
            else if (w_start) r_armed <= 1'b0;
            else              r_armed <= r_armed;

            if (w_start) begin
                r_shadow <= {{(FB-1){1'b0}}, cell_in};
                r_k      <= KW'(1);
            end else if (w_store) begin
                r_shadow[r_k] <= cell_in;
                r_k           <= r_k + KW'(1);
            end else begin
                r_shadow <= r_shadow;
                r_k      <= r_k;
            end
        end
    end

    // Atomic commit and status flags; an INPUT phase clear overrides the commit increment
    always_ff @(posedge clock) begin
        if (reset) begin
            r_display   <= {FB{1'b0}};
            generation  <= {GEN_W{1'b0}};
            frame_valid <= 1'b0;
            extinct     <= 1'b0;
            still_life  <= 1'b0;
        end else begin
            frame_valid <= w_commit;
            if (w_commit) begin
                r_display <= r_shadow;
                extinct   <= (r_shadow == {FB{1'b0}});
            end
            if (w_in) begin
                generation <= {GEN_W{1'b0}};
                still_life <= 1'b0;
            end else if (w_commit) begin
                generation <= generation + GEN_W'(1);
                still_life <= (r_shadow == r_display);
            end
        end
    end

    // Free-running dwell and row sequencing
    always_comb begin
        w_dwell_nxt = r_dwell + DW'(1);
        w_row_nxt   = r_row;
        if (r_dwell == DWELL_LAST) begin
            w_dwell_nxt = {DW{1'b0}};
            w_row_nxt   = (r_row == ROW_LAST) ? {RW{1'b0}} : r_row + RW'(1);
        end else begin
            w_row_nxt   = r_row;
        end
`ifdef GOL_SCAN_BLANK_EN
        w_sel_nxt = (w_dwell_nxt == {DW{1'b0}}) ? {N{1'b0}} : ({{(N-1){1'b0}}, 1'b1} << w_row_nxt);
`else
        w_sel_nxt = {{(N-1){1'b0}}, 1'b1} << w_row_nxt;
`endif
    end

    // Row drive registers; col_out samples the display as it stood before this edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dwell <= {DW{1'b0}};
            r_row   <= {RW{1'b0}};
`ifdef GOL_SCAN_BLANK_EN
            row_sel <= {N{1'b0}};
`else
            row_sel <= {{(N-1){1'b0}}, 1'b1};
`endif
            col_out <= {N{1'b0}};
        end else begin
            r_dwell <= w_dwell_nxt;
            r_row   <= w_row_nxt;
            row_sel <= w_sel_nxt;
            col_out <= r_display[w_row_nxt];
        end
    end

endmodule

// File: tb/tb_gol_frame_scanner.sv
// Randomized self-checking bench for gol_frame_scanner against a frame-level
// reference model (board contents, generation count, flags, time-based scan position).
module tb_gol_frame_scanner;

    localparam int N     = 8;
    localparam int DWELL = 16;
    localparam int GEN_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       phase = 2'b01;
    logic             cell_in = 1'b0;
    logic [N-1:0]     row_sel;
    logic [N-1:0]     col_out;
    logic [GEN_W-1:0] generation;
    logic             frame_valid;
    logic             extinct;
    logic             still_life;

    gol_frame_scanner #(.N(N), .DWELL(DWELL), .GEN_W(GEN_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .phase       (phase),
        .cell_in     (cell_in),
        .row_sel     (row_sel),
        .col_out     (col_out),
        .generation  (generation),
        .frame_valid (frame_valid),
        .extinct     (extinct),
        .still_life  (still_life)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          ticks = 0;
    int          fv_cnt = 0;
    int          fv_tick = -1;
    int          last_bit_tick = 0;
    logic [63:0] m_disp = 64'd0;
    logic [7:0]  m_gen = 8'd0;
    logic        m_ext = 1'b0;
    logic        m_still = 1'b0;

    // One clock: count scan ticks since reset release, sample outputs 1 time unit later
    task automatic step();
        @(posedge clock);
        if (reset) ticks = 0;
        else       ticks++;
        #1;
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_tick = ticks;
        end
    endtask

    function automatic logic [7:0] exp_sel(int t);
        logic [7:0] one = 8'h01;
`ifdef GOL_SCAN_BLANK_EN
        if (t % DWELL == 0) return 8'h00;
`endif
        return one << ((t / DWELL) % N);
    endfunction

    task automatic model_commit(input logic [63:0] f, input logic clr);
        m_still = clr ? 1'b0 : (f == m_disp);
        m_ext   = (f == 64'd0);
        m_disp  = f;
        m_gen   = clr ? 8'd0 : m_gen + 8'd1;
    endtask

    task automatic send_frame(input logic [63:0] f, input logic [1:0] after_ph);
        for (int k = 0; k < 64; k++) begin
            phase   = 2'b10;
            cell_in = f[k];
            step();
        end
        last_bit_tick = ticks;
        phase   = after_ph;
        cell_in = 1'b0;
        step();
        model_commit(f, after_ph == 2'b00);
    endtask

    task automatic capture_rows(output logic [63:0] seen, output logic ok);
        logic [7:0] one = 8'h01;
        ok   = 1'b1;
        seen = 64'd0;
        for (int r = 0; r < N; r++) begin
            int guard = 0;
            while (row_sel !== (one << r) && guard < 2 * N * DWELL) begin
                step();
                guard++;
            end
            if (guard >= 2 * N * DWELL) ok = 1'b0;
            step();
            seen[r*N +: N] = col_out;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        phase = 2'b01;
        step();
        step();
        checks++; if (row_sel !== exp_sel(0)) begin errors++; $display("FAIL reset_row_sel: got %h expected %h", row_sel, exp_sel(0)); end
        checks++; if (col_out !== 8'h00) begin errors++; $display("FAIL reset_col_out: got %h expected 00", col_out); end
        checks++; if (generation !== 8'h00) begin errors++; $display("FAIL reset_generation: got %h expected 00", generation); end
        checks++; if ({frame_valid, extinct, still_life} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {frame_valid, extinct, still_life}); end
        reset = 1'b0;
        repeat (16) step();
        checks++; if (row_sel !== exp_sel(16)) begin errors++; $display("FAIL scan_row1: got %h expected %h", row_sel, exp_sel(16)); end
        repeat (112) step();
        checks++; if (row_sel !== exp_sel(128)) begin errors++; $display("FAIL scan_wrap: got %h expected %h", row_sel, exp_sel(128)); end
    endtask

    task automatic test_glider();
        logic [63:0] f = 64'd0;
        logic [63:0] seen;
        logic        ok;
        int          fv0 = fv_cnt;
        f[1] = 1'b1; f[10] = 1'b1; f[16] = 1'b1; f[17] = 1'b1; f[18] = 1'b1;
        send_frame(f, 2'b01);
        checks++; if (frame_valid !== 1'b1 || fv_tick != last_bit_tick + 1) begin errors++; $display("FAIL glider_fv_latency: got fv=%b at tick %0d expected 1 at tick %0d", frame_valid, fv_tick, last_bit_tick + 1); end
        step();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL glider_fv_pulse: got %b expected 0", frame_valid); end
        checks++; if (generation !== m_gen || m_gen !== 8'd1) begin errors++; $display("FAIL glider_gen: got %0d expected 1", generation); end
        checks++; if ({extinct, still_life} !== 2'b00) begin errors++; $display("FAIL glider_flags: got %b expected 00", {extinct, still_life}); end
        capture_rows(seen, ok);
        checks++; if (ok !== 1'b1 || seen[23:0] !== 24'h070402) begin errors++; $display("FAIL glider_rows012: got %h expected 070402", seen[23:0]); end
        checks++; if (seen !== m_disp) begin errors++; $display("FAIL glider_display: got %h expected %h", seen, m_disp); end
        checks++; if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL glider_fv_count: got %0d expected 1", fv_cnt - fv0); end
    endtask

    task automatic test_abort();
        logic [63:0] seen;
        logic        ok;
        int          fv0 = fv_cnt;
        for (int k = 0; k < 40; k++) begin
            phase   = 2'b10;
            cell_in = 1'($urandom);
            step();
        end
        phase = 2'b01;
        repeat (3) step();
        checks++; if (fv_cnt != fv0) begin errors++; $display("FAIL abort_no_fv: got %0d pulses expected 0", fv_cnt - fv0); end
        checks++; if (generation !== m_gen) begin errors++; $display("FAIL abort_gen: got %0d expected %0d", generation, m_gen); end
        capture_rows(seen, ok);
        checks++; if (ok !== 1'b1 || seen !== m_disp) begin errors++; $display("FAIL abort_display: got %h expected %h", seen, m_disp); end
        send_frame({$urandom, $urandom}, 2'b01);
        checks++; if (generation !== m_gen || fv_cnt - fv0 != 1) begin errors++; $display("FAIL abort_next_commit: got gen %0d fv %0d expected gen %0d fv 1", generation, fv_cnt - fv0, m_gen); end
        capture_rows(seen, ok);
        checks++; if (ok !== 1'b1 || seen !== m_disp) begin errors++; $display("FAIL abort_next_display: got %h expected %h", seen, m_disp); end
    endtask

    task automatic test_still_extinct();
        logic [63:0] blk = 64'd0;
        blk[27] = 1'b1; blk[28] = 1'b1; blk[35] = 1'b1; blk[36] = 1'b1;
        send_frame(blk, 2'b01);
        step();
        send_frame(blk, 2'b01);
        checks++; if (still_life !== 1'b1 || m_still !== 1'b1 || extinct !== 1'b0) begin errors++; $display("FAIL still_block: got still=%b ext=%b expected still=1 ext=0", still_life, extinct); end
        step();
        send_frame(64'd0, 2'b01);
        checks++; if (extinct !== 1'b1 || still_life !== 1'b0) begin errors++; $display("FAIL extinct_zero: got ext=%b still=%b expected ext=1 still=0", extinct, still_life); end
    endtask

    task automatic test_rearm_clear();
        logic [129:0] bits;
        logic [63:0]  seen;
        logic         ok;
        int           fv0 = fv_cnt;
        for (int k = 0; k < 130; k++) begin
            bits[k] = 1'($urandom);
            phase   = 2'b10;
            cell_in = bits[k];
            step();
        end
        phase = 2'b01;
        step();
        model_commit(bits[63:0], 1'b0);
        checks++; if (fv_cnt - fv0 != 1) begin errors++; $display("FAIL rearm_one_commit: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (generation !== m_gen || still_life !== m_still || extinct !== m_ext) begin errors++; $display("FAIL rearm_status: got gen %0d s%b e%b expected gen %0d s%b e%b", generation, still_life, extinct, m_gen, m_still, m_ext); end
        capture_rows(seen, ok);
        checks++; if (ok !== 1'b1 || seen !== m_disp) begin errors++; $display("FAIL rearm_display: got %h expected %h", seen, m_disp); end
        phase = 2'b00;
        step();
        phase = 2'b01;
        step();
        m_gen   = 8'd0;
        m_still = 1'b0;
        checks++; if (generation !== 8'd0 || still_life !== 1'b0 || extinct !== m_ext) begin errors++; $display("FAIL input_clear: got gen %0d s%b e%b expected gen 0 s0 e%b", generation, still_life, extinct, m_ext); end
        capture_rows(seen, ok);
        checks++; if (ok !== 1'b1 || seen !== m_disp) begin errors++; $display("FAIL input_keeps_display: got %h expected %h", seen, m_disp); end
    endtask

    task automatic test_commit_with_input();
        logic [63:0] seen;
        logic        ok;
        logic [63:0] same = m_disp;
        int          fv0 = fv_cnt;
        send_frame({$urandom, $urandom}, 2'b01);
        step();
        same = m_disp;
        send_frame(same, 2'b00);
        phase = 2'b01;
        step();
        checks++; if (generation !== 8'd0 || still_life !== 1'b0 || extinct !== m_ext) begin errors++; $display("FAIL commit_input_clear: got gen %0d s%b e%b expected gen 0 s0 e%b", generation, still_life, extinct, m_ext); end
        checks++; if (fv_cnt - fv0 != 2) begin errors++; $display("FAIL commit_input_fv: got %0d expected 2", fv_cnt - fv0); end
        capture_rows(seen, ok);
        checks++; if (ok !== 1'b1 || seen !== m_disp) begin errors++; $display("FAIL commit_input_display: got %h expected %h", seen, m_disp); end
    endtask

    task automatic test_gen_wrap();
        logic [63:0] f;
        int          fv0 = fv_cnt;
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(3))
                0:       f = m_disp;
                1:       f = 64'd0;
                default: f = {$urandom, $urandom};
            endcase
            send_frame(f, 2'b01);
            checks++; if (generation !== m_gen || still_life !== m_still || extinct !== m_ext) begin errors++; $display("FAIL wrap_frame%0d: got gen %0d s%b e%b expected gen %0d s%b e%b", i, generation, still_life, extinct, m_gen, m_still, m_ext); end
            if (i == 254) begin
                checks++; if (generation !== 8'd255) begin errors++; $display("FAIL wrap_gen255: got %0d expected 255", generation); end
            end
        end
        checks++; if (generation !== 8'd0 || fv_cnt - fv0 != 256) begin errors++; $display("FAIL wrap_gen0: got gen %0d fv %0d expected gen 0 fv 256", generation, fv_cnt - fv0); end
    endtask

    task automatic test_scan_random();
        int r;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 40)) step();
            r = (ticks / DWELL) % N;
            checks++; if (row_sel !== exp_sel(ticks)) begin errors++; $display("FAIL scan_row_sel: got %h expected %h at tick %0d", row_sel, exp_sel(ticks), ticks); end
            checks++; if (col_out !== m_disp[r*N +: N]) begin errors++; $display("FAIL scan_col_out: got %h expected %h row %0d", col_out, m_disp[r*N +: N], r); end
        end
    endtask

    initial begin
        test_reset();
        test_glider();
        test_abort();
        test_still_extinct();
        test_rearm_clear();
        test_commit_with_input();
        test_gen_wrap();
        test_scan_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
